// File: rtl/arbitro_rr_entrada.sv
// Weighted round-robin arbiter draining four show-ahead VC FIFOs into one registered stream.
// Optional build macro ARB_PRIORIDAD_EN gives channel 0 strict priority over the rotation.
module arbitro_rr_entrada #(
    parameter int WORD_SIZE = 12,
    parameter int PESO      = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*WORD_SIZE-1:0] data_in,
    input  logic [3:0]             fifos_empty,
    input  logic                   fifo_out_almost_full,
    output logic [3:0]             pop,
    output logic [WORD_SIZE-1:0]   data_out,
    output logic                   push,
    output logic [1:0]             estado,
    input  logic [1:0]             idx_cuenta,
    input  logic                   req_cuenta,
    output logic [4:0]             cuenta,
    output logic                   valid_cuenta
);

    // state  | meaning
    // IDLE   | every input FIFO empty
    // ACTIVO | a pop was granted in the previous cycle
    // PAUSA  | work pending but downstream almost full
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVO = 2'd1,
        PAUSA  = 2'd2
    } estado_t;

    localparam logic [2:0] PESO_W = 3'(PESO);

    estado_t    estado_q;
    estado_t    estado_d;
    logic [1:0] ptr;
    logic [2:0] racha;
    logic [1:0] inicio;
    logic [1:0] cand;
    logic [1:0] sel;
    logic       hay_grant;
    logic       prio;
    logic [3:0] grant;
    logic [4:0] cnt [4];

`ifdef ARB_PRIORIDAD_EN
    assign prio = ~fifos_empty[0] & ~fifo_out_almost_full;
`else
    assign prio = 1'b0;
`endif

    // Circular search from the start point; lower offsets overwrite higher ones.
    always_comb begin
        inicio    = (racha < PESO_W) ? ptr : ptr + 2'd1;
        cand      = inicio;
        sel       = inicio;
        hay_grant = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            cand = inicio + 2'(k);
            if (!fifos_empty[cand]) begin
                sel       = cand;
                hay_grant = 1'b1;
            end
        end
        if (fifo_out_almost_full) begin
            hay_grant = 1'b0;
        end
        if (prio) begin
            sel       = 2'd0;
            hay_grant = 1'b1;
        end
    end

    assign grant = hay_grant ? (4'b0001 << sel) : 4'b0000;
    assign pop   = reset ? grant : 4'b0000;

    // Priority pops of channel 0 leave the rotation untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr   <= 2'd0;
            racha <= 3'd0;
        end else if (hay_grant && !prio) begin
            if (sel == ptr && racha < PESO_W) begin
                racha <= racha + 3'd1;
            end else begin
                ptr   <= sel;
                racha <= 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
            push     <= 1'b0;
        end else begin
            push <= hay_grant;
            if (hay_grant) begin
                data_out <= data_in[int'(sel)*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= IDLE;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = IDLE;
        case (estado_q)
            IDLE, ACTIVO, PAUSA: begin
                if (hay_grant) begin
                    estado_d = ACTIVO;
                end else if (&fifos_empty) begin
                    estado_d = IDLE;
                end else begin
                    estado_d = PAUSA;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    assign estado = estado_q;

    // Read-back samples the register before this cycle's increment lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 5'd0;
            end
            cuenta       <= 5'd0;
            valid_cuenta <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (grant[i]) begin
                    cnt[i] <= cnt[i] + 5'd1;
                end
            end
            valid_cuenta <= req_cuenta;
            cuenta       <= req_cuenta ? cnt[idx_cuenta] : 5'd0;
        end
    end

endmodule

// File: tb/tb_arbitro_rr_entrada.sv
// Directed bench for arbitro_rr_entrada; expectations hand-derived for PESO=2.
module tb_arbitro_rr_entrada;

    logic        clk;
    logic        reset;
    logic [47:0] data_in;
    logic [3:0]  fifos_empty;
    logic        fifo_out_almost_full;
    logic [3:0]  pop;
    logic [11:0] data_out;
    logic        push;
    logic [1:0]  estado;
    logic [1:0]  idx_cuenta;
    logic        req_cuenta;
    logic [4:0]  cuenta;
    logic        valid_cuenta;

    int total = 0;
    int bad   = 0;

    arbitro_rr_entrada #(.WORD_SIZE(12), .PESO(2)) dut (
        .clk                  (clk),
        .reset                (reset),
        .data_in              (data_in),
        .fifos_empty          (fifos_empty),
        .fifo_out_almost_full (fifo_out_almost_full),
        .pop                  (pop),
        .data_out             (data_out),
        .push                 (push),
        .estado               (estado),
        .idx_cuenta           (idx_cuenta),
        .req_cuenta           (req_cuenta),
        .cuenta               (cuenta),
        .valid_cuenta         (valid_cuenta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset                = 1'b0;
        fifos_empty          = 4'hF;
        fifo_out_almost_full = 1'b0;
        req_cuenta           = 1'b0;
        idx_cuenta           = 2'd0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset                = 1'b0;
        data_in              = {12'h444, 12'h333, 12'h222, 12'h111};
        fifos_empty          = 4'h0;
        fifo_out_almost_full = 1'b0;
        req_cuenta           = 1'b1;
        idx_cuenta           = 2'd0;
        #1;
        total++; if (pop !== 4'b0000) begin bad++; $display("FAIL reset_pop: got %b want 0000", pop); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (pop !== 4'b0000) begin bad++; $display("FAIL reset_pop_hold: got %b want 0000", pop); end
        total++; if (push !== 1'b0) begin bad++; $display("FAIL reset_push: got %b want 0", push); end
        total++; if (data_out !== 12'h000) begin bad++; $display("FAIL reset_data: got %h want 000", data_out); end
        total++; if (estado !== 2'd0) begin bad++; $display("FAIL reset_estado: got %0d want 0", estado); end
        total++; if (cuenta !== 5'd0) begin bad++; $display("FAIL reset_cuenta: got %0d want 0", cuenta); end
        total++; if (valid_cuenta !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_cuenta); end
        req_cuenta = 1'b0;
        reset      = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        data_in     = {12'h444, 12'h333, 12'h222, 12'h5A5};
        fifos_empty = 4'b1110;
        #1;
        total++; if (pop !== 4'b0001) begin bad++; $display("FAIL mid_pop_before: got %b want 0001", pop); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (pop !== 4'b0000) begin bad++; $display("FAIL mid_pop_in_reset: got %b want 0000", pop); end
        @(posedge clk);
        #1;
        total++; if (push !== 1'b0) begin bad++; $display("FAIL mid_push_dropped: got %b want 0", push); end
        total++; if (data_out !== 12'h000) begin bad++; $display("FAIL mid_data_dropped: got %h want 000", data_out); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        data_in     = {12'h444, 12'hABC, 12'h222, 12'h111};
        fifos_empty = 4'b1011;
        #1;
        total++; if (pop !== 4'b0100) begin bad++; $display("FAIL single_pop: got %b want 0100", pop); end
        @(posedge clk);
        #1;
        total++; if (push !== 1'b1) begin bad++; $display("FAIL single_push: got %b want 1", push); end
        total++; if (data_out !== 12'hABC) begin bad++; $display("FAIL single_data: got %h want abc", data_out); end
        total++; if (estado !== 2'd1) begin bad++; $display("FAIL single_estado: got %0d want 1", estado); end
        fifos_empty = 4'hF;
        #1;
        total++; if (pop !== 4'b0000) begin bad++; $display("FAIL single_empty_pop: got %b want 0000", pop); end
        @(posedge clk);
        #1;
        total++; if (push !== 1'b0) begin bad++; $display("FAIL single_empty_push: got %b want 0", push); end
        total++; if (data_out !== 12'hABC) begin bad++; $display("FAIL single_data_hold: got %h want abc", data_out); end
        total++; if (estado !== 2'd0) begin bad++; $display("FAIL single_estado_idle: got %0d want 0", estado); end
    endtask

    task automatic test_rotation();
        logic [3:0]  exp_pop  [9];
        logic [11:0] exp_data [9];
        logic [11:0] heads    [4];
        exp_pop = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
        heads   = '{12'h100, 12'h200, 12'h300, 12'h400};
        exp_data = '{12'h100, 12'h100, 12'h200, 12'h200, 12'h300, 12'h300, 12'h400, 12'h400, 12'h100};
        do_reset();
        data_in     = {heads[3], heads[2], heads[1], heads[0]};
        fifos_empty = 4'h0;
        for (int n = 0; n < 9; n++) begin
            #1;
            total++; if (pop !== exp_pop[n]) begin bad++; $display("FAIL rot_pop[%0d]: got %b want %b", n, pop, exp_pop[n]); end
            @(posedge clk);
            #1;
            total++; if (push !== 1'b1 || data_out !== exp_data[n]) begin
                bad++; $display("FAIL rot_out[%0d]: got push=%b data=%h want push=1 data=%h", n, push, data_out, exp_data[n]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        data_in     = {12'h444, 12'h333, 12'h222, 12'h111};
        fifos_empty = 4'b1001;
        #1;
        total++; if (pop !== 4'b0010) begin bad++; $display("FAIL bp_first_pop: got %b want 0010", pop); end
        @(posedge clk);
        #1;
        fifo_out_almost_full = 1'b1;
        #1;
        total++; if (pop !== 4'b0000) begin bad++; $display("FAIL bp_pop_blocked: got %b want 0000", pop); end
        @(posedge clk);
        #1;
        total++; if (push !== 1'b0) begin bad++; $display("FAIL bp_push: got %b want 0", push); end
        total++; if (estado !== 2'd2) begin bad++; $display("FAIL bp_estado: got %0d want 2", estado); end
        @(posedge clk);
        #1;
        fifo_out_almost_full = 1'b0;
        #1;
        total++; if (pop !== 4'b0010) begin bad++; $display("FAIL bp_resume_pop: got %b want 0010", pop); end
        @(posedge clk);
        #1;
        total++; if (estado !== 2'd1) begin bad++; $display("FAIL bp_resume_estado: got %0d want 1", estado); end
        total++; if (data_out !== 12'h222) begin bad++; $display("FAIL bp_resume_data: got %h want 222", data_out); end
        #1;
        total++; if (pop !== 4'b0100) begin bad++; $display("FAIL bp_rotate_pop: got %b want 0100", pop); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_counter_wrap();
        do_reset();
        data_in     = {12'h444, 12'h333, 12'h222, 12'h111};
        fifos_empty = 4'b1101;
        for (int n = 0; n < 33; n++) begin
            #1;
            total++; if (pop !== 4'b0010) begin bad++; $display("FAIL wrap_pop[%0d]: got %b want 0010", n, pop); end
            @(posedge clk);
            #1;
        end
        fifos_empty = 4'hF;
        req_cuenta  = 1'b1;
        idx_cuenta  = 2'd1;
        @(posedge clk);
        #1;
        total++; if (cuenta !== 5'd1) begin bad++; $display("FAIL wrap_cuenta: got %0d want 1", cuenta); end
        total++; if (valid_cuenta !== 1'b1) begin bad++; $display("FAIL wrap_valid: got %b want 1", valid_cuenta); end
        req_cuenta = 1'b0;
        @(posedge clk);
        #1;
        total++; if (valid_cuenta !== 1'b0) begin bad++; $display("FAIL wrap_valid_drop: got %b want 0", valid_cuenta); end
        total++; if (cuenta !== 5'd0) begin bad++; $display("FAIL wrap_cuenta_zero: got %0d want 0", cuenta); end
        fifos_empty = 4'b1101;
        req_cuenta  = 1'b1;
        @(posedge clk);
        #1;
        total++; if (cuenta !== 5'd1) begin bad++; $display("FAIL preinc_cuenta: got %0d want 1", cuenta); end
        fifos_empty = 4'hF;
        @(posedge clk);
        #1;
        total++; if (cuenta !== 5'd2) begin bad++; $display("FAIL postinc_cuenta: got %0d want 2", cuenta); end
        idx_cuenta = 2'd3;
        @(posedge clk);
        #1;
        total++; if (cuenta !== 5'd0) begin bad++; $display("FAIL idle_ch_cuenta: got %0d want 0", cuenta); end
        req_cuenta = 1'b0;
    endtask

    task automatic test_macro();
        logic [3:0] exp_pop [5];
`ifdef ARB_PRIORIDAD_EN
        exp_pop = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_pop = '{4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b0001};
`endif
        do_reset();
        data_in     = {12'h444, 12'h333, 12'h222, 12'h111};
        fifos_empty = 4'b0110;
        for (int n = 0; n < 5; n++) begin
            #1;
            total++; if (pop !== exp_pop[n]) begin bad++; $display("FAIL macro_pop[%0d]: got %b want %b", n, pop, exp_pop[n]); end
            @(posedge clk);
            #1;
        end
        fifos_empty = 4'b0111;
        #1;
        total++; if (pop !== 4'b1000) begin bad++; $display("FAIL macro_ch0_empty: got %b want 1000", pop); end
        @(posedge clk);
        #1;
        total++; if (data_out !== 12'h444) begin bad++; $display("FAIL macro_data: got %h want 444", data_out); end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_single();
        test_rotation();
        test_backpressure();
        test_counter_wrap();
        test_macro();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbitro_rr_entrada.md
Name: arbitro_rr_entrada

Overview:
- Round-robin arbiter that drains four input VC FIFOs (show-ahead / first-word-fall-through) into a single 12-bit output stream.
- Pops at most one FIFO per cycle; the pop is weighted by a burst limit and throttled by the downstream almost-full flag.
- Sits upstream of the 1-to-4 routing arbiter, feeding its source FIFO.
- Keeps a per-channel pop counter that can be read back.

Parameters:
- WORD_SIZE, 12, data word width.
- PESO, 2, max consecutive pops granted to one channel before rotating (1..7).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  4*WORD_SIZE  packed FIFO heads; slice i = [i*WORD_SIZE +: WORD_SIZE].
- fifos_empty  input  4  empty flag per input FIFO.
- fifo_out_almost_full  input  1  downstream FIFO almost full.
- pop  output  4  one-hot pop to input FIFOs, combinational.
- data_out  output  WORD_SIZE  registered word to downstream FIFO.
- push  output  1  registered write strobe for data_out.
- estado  output  2  registered FSM state.
- idx_cuenta  input  2  channel selected for counter read.
- req_cuenta  input  1  counter read request.
- cuenta  output  5  registered counter value.
- valid_cuenta  output  1  cuenta valid strobe.

Behaviour:
- Reset (reset=0, asynchronous):
  - data_out=0, push=0, cuenta=0, valid_cuenta=0, estado=IDLE(0).
  - Pointer ptr=0, burst counter racha=0, all four channel counters=0.
  - pop forced to 0 combinationally while reset=0, including mid-transfer; any in-flight word is dropped.
- Grant in cycle t (combinational):
  - No grant if fifo_out_almost_full=1 or all fifos_empty=1.
  - Otherwise the search start is ptr if racha<PESO, else ptr+1 (mod 4).
  - Search circularly from the start for the first channel with fifos_empty[i]=0; pop=onehot(i).
- Pointer update at the edge ending cycle t:
  - If granted i==ptr: racha<=racha+1.
  - If granted i!=ptr: ptr<=i, racha<=1.
  - If no grant: ptr and racha hold.
- Datapath, latency 1:
  - If pop[i] is asserted in t, then at t+1: push=1 and data_out=data_in slice i as sampled in t.
  - If there is no pop, push=0 and data_out holds its previous value.
- FSM states (registered from cycle-t conditions):
  - IDLE=0: all empty.
  - ACTIVO=1: grant issued.
  - PAUSA=2: some FIFO non-empty but fifo_out_almost_full=1.
  - Transitions are direct between any pair; code 3 is unused and recovers to IDLE.
- Counters:
  - cnt[i], 5 bits, incremented on each pop[i]; wraps 31->0.
  - If req_cuenta=1 in t: at t+1, cuenta=cnt[idx_cuenta] (pre-increment value when a pop of the same channel occurs in t) and valid_cuenta=1.
  - Else valid_cuenta=0 and cuenta=0.
- Boundary cases:
  - Owner empties before PESO: the search continues circularly and the switch resets racha.
  - almost_full rising while a channel holds the burst: racha is frozen and the burst resumes on release.
  - Only one non-empty channel: it is granted every cycle regardless of PESO, with racha reloaded to 1 on each re-grant after PESO (it is the search result of ptr+1 wrapping back).

Optional Feature:
- Macro ARB_PRIORIDAD_EN.
- Defined:
  - Channel 0 has strict priority: whenever fifos_empty[0]=0 and almost_full=0, pop=4'b0001.
  - Such priority pops leave ptr and racha unchanged.
  - Channels 1-3 are round-robin only when channel 0 is empty.
- Undefined: all four channels are plain weighted round-robin as above.

Test Plan:
- Reset: reset=0 at time 0 for 2 cycles with FIFOs non-empty -> pop=0, push=0, data_out=0, estado=0, cuenta=0; then reset=1.
- Single channel: only FIFO2 non-empty, head 12'hABC, almost_full=0 -> pop=4'b0100 in t; at t+1 push=1, data_out=12'hABC, estado=1.
- Rotation, PESO=2: all four non-empty for 8 cycles -> pop sequence 0001,0001,0010,0010,0100,0100,1000,1000, then 0001.
- Backpressure:
  - almost_full=1 after the first ch1 pop -> pop=0, push=0 next cycle, estado=2.
  - On release, the next pop is ch1 (racha resumes at 1 -> one more ch1 pop), then ch2.
- Counter wrap: 33 pops of ch1, then req_cuenta=1, idx_cuenta=1 -> next cycle cuenta=1, valid_cuenta=1; following cycle valid_cuenta=0.
- Macro, with ch0 and ch3 non-empty:
  - Without ARB_PRIORIDAD_EN: pop 0001,0001,1000,1000,0001.
  - With ARB_PRIORIDAD_EN: pop 0001 every cycle until ch0 empties, then 1000.
